// File: rtl/dot_arbiter_if.sv
// dot_arbiter_if: requester-side and fp32_dot-side signals of the dot arbiter.
// Latency: none (wires only).
// Backpressure: carried by req_ready_out; the result path has no backpressure.
interface dot_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16
);
  logic [NUM_REQ-1:0]             req_valid_in;
  logic [NUM_REQ-1:0][3:0][31:0]  req_a_in;
  logic [NUM_REQ-1:0][3:0][31:0]  req_b_in;
  logic [NUM_REQ-1:0]             req_ready_out;
  logic                           dot_valid_out;
  logic [3:0][31:0]               dot_a_out;
  logic [3:0][31:0]               dot_b_out;
  logic                           dot_valid_in;
  logic [31:0]                    dot_c_in;
  logic [NUM_REQ-1:0]             res_valid_out;
  logic [31:0]                    res_c_out;
  logic [$clog2(DEPTH):0]         outstanding_out;
  logic                           err_out;

  // Arbiter side.
  modport slave (
    input  req_valid_in, req_a_in, req_b_in, dot_valid_in, dot_c_in,
    output req_ready_out, dot_valid_out, dot_a_out, dot_b_out,
           res_valid_out, res_c_out, outstanding_out, err_out
  );

  // Requesters plus fp32_dot side.
  modport master (
    output req_valid_in, req_a_in, req_b_in, dot_valid_in, dot_c_in,
    input  req_ready_out, dot_valid_out, dot_a_out, dot_b_out,
           res_valid_out, res_c_out, outstanding_out, err_out
  );
endinterface

// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin share of one fp32_dot among NUM_REQ requesters; a tag FIFO routes results back.
// Latency: 1 cycle from request handshake to dot issue, 1 cycle from dot result to res strobe.
// Backpressure: req_ready_out drops while DEPTH ops are outstanding; results cannot be stalled.
module dot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  dot_arbiter_if.slave bus
);
  localparam int            IW       = $clog2(NUM_REQ);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [IW-1:0]          r_rr_ptr;
  logic [IW-1:0]          r_tag_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_err;
  logic                   r_dot_valid;
  logic [3:0][31:0]       r_dot_a;
  logic [3:0][31:0]       r_dot_b;
  logic [NUM_REQ-1:0]     r_res_valid;
  logic [31:0]            r_res_c;

  logic [IW:0]            w_cand;
  logic [IW-1:0]          w_gnt_idx;
  logic                   w_gnt_any;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [IW-1:0]          w_head_tag;
  logic [NUM_REQ-1:0]     w_ready;
  logic [NUM_REQ-1:0]     w_res_onehot;

  // Round-robin search starting after r_rr_ptr; walking the distance downwards lets the nearest valid requester win.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IW+1)'(NUM_REQ);
      end
      if (bus.req_valid_in[w_cand[IW-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[IW-1:0];
      end
    end
  end

  // Full uses the registered count, so a same-cycle pop does not open a slot early.
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = w_gnt_any & ~w_full & ~rst_in;
  assign w_pop      = bus.dot_valid_in & ~w_empty;
  assign w_head_tag = r_tag_mem[r_rd_ptr];

  // Ready is the one-hot grant, present only when the push can be taken.
  always_comb begin
    w_ready = '0;
    if (w_push) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Decode the FIFO head tag into the per-requester result strobe.
  always_comb begin
    w_res_onehot = '0;
    w_res_onehot[w_head_tag] = 1'b1;
  end

  // Issue stage: register granted operands and move the RR pointer only on a handshake.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rr_ptr    <= IW'(NUM_REQ - 1);
      r_dot_valid <= 1'b0;
      r_dot_a     <= '0;
      r_dot_b     <= '0;
    end else begin
      r_dot_valid <= w_push;
      if (w_push) begin
        r_rr_ptr <= w_gnt_idx;
        r_dot_a  <= bus.req_a_in[w_gnt_idx];
        r_dot_b  <= bus.req_b_in[w_gnt_idx];
      end
    end
  end

  // Tag storage: entries are only read while the count says they are live, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  // Tag FIFO pointers/count, result return, and the sticky orphan-result flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_res_valid <= '0;
      r_res_c     <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_res_c  <= bus.dot_c_in;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_res_valid <= w_pop ? w_res_onehot : '0;
      if (bus.dot_valid_in && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready_out   = w_ready;
  assign bus.dot_valid_out   = r_dot_valid;
  assign bus.dot_a_out       = r_dot_a;
  assign bus.dot_b_out       = r_dot_b;
  assign bus.res_valid_out   = r_res_valid;
  assign bus.res_c_out       = r_res_c;
  assign bus.outstanding_out = r_count;
  assign bus.err_out         = r_err;
endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: vector table, directed corner sequences and random traffic against a queue-based model.
// Latency: expects 1-cycle issue and 1-cycle return.
// Backpressure: requesters hold valid/operands until ready; the dot stub returns results at random.
module tb_dot_arbiter;
  localparam int NR = 4;
  localparam int DP = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  dot_arbiter_if #(.NUM_REQ(NR), .DEPTH(DP)) bus ();
  dot_arbiter #(.NUM_REQ(NR), .DEPTH(DP)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: last granted requester, queue of in-flight tags, expected registered outputs.
  int              m_last;
  int              m_q[$];
  bit              m_err;
  bit              m_dot_v;
  logic [127:0]    m_dot_a;
  logic [127:0]    m_dot_b;
  logic [NR-1:0]   m_res_v;
  logic [31:0]     m_res_c;
  bit              hs_last;
  int              g_last;

  typedef struct {
    logic [NR-1:0] vld;
    bit            dv;
    logic [31:0]   c;
    logic [NR-1:0] rdy;
    logic [NR-1:0] res;
    int            outst;
    bit            err;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] op_a(input int r);
    return {4{32'h1000_0000 + 32'(r)}};
  endfunction

  function automatic logic [127:0] op_b(input int r);
    return {4{32'h2000_0000 + 32'(r)}};
  endfunction

  task automatic set_fixed_ops();
    for (int r = 0; r < NR; r++) begin
      bus.req_a_in[r] = op_a(r);
      bus.req_b_in[r] = op_b(r);
    end
  endtask

  // One clock: predict the grant from current inputs, cross the edge, update the model, compare.
  task automatic do_cycle();
    int g;
    logic [NR-1:0] exp_rdy;
    bit dv;
    logic [31:0] c;
    logic [127:0] ga;
    logic [127:0] gb;
    #1;
    g = -1;
    for (int k = 1; k <= NR; k++) begin
      int r;
      r = (m_last + k) % NR;
      if (g < 0 && bus.req_valid_in[r]) g = r;
    end
    hs_last = (g >= 0) && (m_q.size() < DP);
    exp_rdy = '0;
    ga = '0;
    gb = '0;
    if (hs_last) begin
      exp_rdy[g] = 1'b1;
      ga = bus.req_a_in[g];
      gb = bus.req_b_in[g];
    end
    chk("ready", bus.req_ready_out, exp_rdy);
    dv = bus.dot_valid_in;
    c  = bus.dot_c_in;
    @(posedge clk_in);
    #1;
    m_res_v = '0;
    if (dv) begin
      if (m_q.size() > 0) begin
        int t;
        t = m_q.pop_front();
        m_res_v[t] = 1'b1;
        m_res_c = c;
      end else begin
        m_err = 1'b1;
      end
    end
    m_dot_v = hs_last;
    if (hs_last) begin
      m_dot_a = ga;
      m_dot_b = gb;
      m_q.push_back(g);
      m_last = g;
      g_last = g;
    end
    chk("dot_valid", bus.dot_valid_out, m_dot_v);
    chk("dot_a", bus.dot_a_out, m_dot_a);
    chk("dot_b", bus.dot_b_out, m_dot_b);
    chk("res_valid", bus.res_valid_out, m_res_v);
    chk("res_c", bus.res_c_out, m_res_c);
    chk("outstanding", bus.outstanding_out, m_q.size());
    chk("err", bus.err_out, m_err);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    bus.req_valid_in = '0;
    bus.dot_valid_in = 1'b0;
    bus.dot_c_in = '0;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    chk("rst_ready", bus.req_ready_out, 0);
    chk("rst_dot_valid", bus.dot_valid_out, 0);
    chk("rst_dot_a", bus.dot_a_out, 0);
    chk("rst_dot_b", bus.dot_b_out, 0);
    chk("rst_res_valid", bus.res_valid_out, 0);
    chk("rst_res_c", bus.res_c_out, 0);
    chk("rst_outstanding", bus.outstanding_out, 0);
    chk("rst_err", bus.err_out, 0);
    rst_in = 1'b0;
    m_last = NR - 1;
    m_q.delete();
    m_err = 1'b0;
    m_dot_v = 1'b0;
    m_dot_a = '0;
    m_dot_b = '0;
    m_res_v = '0;
    m_res_c = '0;
    hs_last = 1'b0;
    g_last = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.req_valid_in = '0;
    bus.dot_valid_in = 1'b0;
    bus.dot_c_in = '0;
    set_fixed_ops();

    // Hand-derived vectors from reset: RR order, push+pop, tag routing, spurious result.
    tbl[0]  = '{4'b1111, 0, 32'h0,         4'b0001, 4'b0000, 1, 0};
    tbl[1]  = '{4'b1111, 0, 32'h0,         4'b0010, 4'b0000, 2, 0};
    tbl[2]  = '{4'b1111, 1, 32'hC000_0002, 4'b0100, 4'b0001, 2, 0};
    tbl[3]  = '{4'b1000, 1, 32'hC000_0003, 4'b1000, 4'b0010, 2, 0};
    tbl[4]  = '{4'b0000, 1, 32'hC000_0004, 4'b0000, 4'b0100, 1, 0};
    tbl[5]  = '{4'b0011, 0, 32'h0,         4'b0001, 4'b0000, 2, 0};
    tbl[6]  = '{4'b0011, 1, 32'hC000_0006, 4'b0010, 4'b1000, 2, 0};
    tbl[7]  = '{4'b0001, 1, 32'hC000_0007, 4'b0001, 4'b0001, 2, 0};
    tbl[8]  = '{4'b0000, 1, 32'hC000_0008, 4'b0000, 4'b0010, 1, 0};
    tbl[9]  = '{4'b0000, 1, 32'hC000_0009, 4'b0000, 4'b0001, 0, 0};
    tbl[10] = '{4'b0000, 1, 32'hC000_000A, 4'b0000, 4'b0000, 0, 1};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.req_valid_in = tbl[i].vld;
      bus.dot_valid_in = tbl[i].dv;
      bus.dot_c_in = tbl[i].c;
      #1;
      chk("tbl_ready", bus.req_ready_out, tbl[i].rdy);
      do_cycle();
      chk("tbl_res_valid", bus.res_valid_out, tbl[i].res);
      if (tbl[i].res != '0) chk("tbl_res_c", bus.res_c_out, tbl[i].c);
      chk("tbl_outstanding", bus.outstanding_out, tbl[i].outst);
      chk("tbl_err", bus.err_out, tbl[i].err);
    end
    bus.dot_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      chk("err_sticky", bus.err_out, 1);
      chk("spurious_no_res", bus.res_valid_out, 0);
    end

    // Single requester with real fp32 operands: 1+2+3+4 = 10.0.
    do_reset();
    bus.req_a_in[1] = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    bus.req_b_in[1] = {4{32'h3F80_0000}};
    bus.req_valid_in = 4'b0010;
    #1;
    chk("single_ready", bus.req_ready_out, 4'b0010);
    do_cycle();
    chk("single_dot_valid", bus.dot_valid_out, 1);
    chk("single_dot_a", bus.dot_a_out, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
    bus.req_valid_in = '0;
    bus.dot_valid_in = 1'b1;
    bus.dot_c_in = 32'h4120_0000;
    do_cycle();
    bus.dot_valid_in = 1'b0;
    chk("single_res_valid", bus.res_valid_out, 4'b0010);
    chk("single_res_c", bus.res_c_out, 32'h4120_0000);
    set_fixed_ops();

    // Continuous contention from reset: grants rotate 0,1,2,3 and results come back in issue order.
    do_reset();
    bus.req_valid_in = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
      chk("rr_grant", g_last, i % 4);
    end
    bus.req_valid_in = '0;
    bus.dot_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dot_c_in = 32'h5000_0000 + 32'(i);
      do_cycle();
      chk("rr_res_valid", bus.res_valid_out, 4'b0001 << (i % 4));
    end
    bus.dot_valid_in = 1'b0;

    // Fill to DEPTH, confirm stall, then a single return reopens ready one cycle later.
    do_reset();
    bus.req_valid_in = 4'b1111;
    for (int i = 0; i < DP; i++) do_cycle();
    chk("full_outstanding", bus.outstanding_out, DP);
    do_cycle();
    chk("full_stall_ready", bus.req_ready_out, 0);
    bus.dot_valid_in = 1'b1;
    bus.dot_c_in = 32'h6000_0001;
    #1;
    chk("full_pop_cycle_ready", bus.req_ready_out, 0);
    do_cycle();
    bus.dot_valid_in = 1'b0;
    chk("full_after_pop", bus.outstanding_out, DP - 1);
    #1;
    chk("full_reassert", bus.req_ready_out, 4'b0001);
    do_cycle();
    bus.req_valid_in = '0;
    bus.dot_valid_in = 1'b1;
    for (int i = 0; i < DP; i++) do_cycle();
    bus.dot_valid_in = 1'b0;
    chk("full_drained", bus.outstanding_out, 0);

    // Push and pop together at count 5.
    do_reset();
    bus.req_valid_in = 4'b1111;
    for (int i = 0; i < 5; i++) do_cycle();
    chk("pp_count5", bus.outstanding_out, 5);
    bus.dot_valid_in = 1'b1;
    bus.dot_c_in = 32'h7000_0001;
    do_cycle();
    chk("pp_count_hold1", bus.outstanding_out, 5);
    chk("pp_route1", bus.res_valid_out, 4'b0001);
    bus.dot_c_in = 32'h7000_0002;
    do_cycle();
    chk("pp_count_hold2", bus.outstanding_out, 5);
    chk("pp_route2", bus.res_valid_out, 4'b0010);
    bus.dot_valid_in = 1'b0;
    bus.req_valid_in = '0;

    // Reset with ops in flight, then first grant goes to requester 0.
    do_reset();
    bus.req_valid_in = 4'b1111;
    for (int i = 0; i < 3; i++) do_cycle();
    chk("inflight3", bus.outstanding_out, 3);
    do_reset();
    bus.req_valid_in = 4'b1111;
    #1;
    chk("post_rst_ready", bus.req_ready_out, 4'b0001);
    do_cycle();
    chk("post_rst_grant", g_last, 0);

    // Random traffic: requesters hold until accepted; dot stub returns results at varying rates.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if (!bus.req_valid_in[r] && ($urandom_range(1, 0) == 1)) begin
          bus.req_valid_in[r] = 1'b1;
          bus.req_a_in[r] = {$urandom, $urandom, $urandom, $urandom};
          bus.req_b_in[r] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      bus.dot_valid_in = (m_q.size() > 0) &&
                         ($urandom_range(99, 0) < (((cyc / 200) % 2 == 1) ? 15 : 70));
      bus.dot_c_in = $urandom;
      do_cycle();
      if (hs_last) bus.req_valid_in[g_last] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
